// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// resolves EX/MEM and MEM/WB forwarding, and flags load-use hazards back to decode.
module idex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [REG_AW-1:0] InRs,
    input  logic [REG_AW-1:0] InRt,
    input  logic [DATA_W-1:0] InRsData,
    input  logic [DATA_W-1:0] InRtData,
    input  logic [DATA_W-1:0] InImm,
    input  logic              InAluSrc,
    input  logic [1:0]        InAluCtrl,
    input  logic [REG_AW-1:0] InWriteReg,
    input  logic [3:0]        InCtrl,
    input  logic              ExMemRegWrite,
    input  logic [REG_AW-1:0] ExMemWriteReg,
    input  logic [DATA_W-1:0] ExMemResult,
    input  logic              MemWbRegWrite,
    input  logic [REG_AW-1:0] MemWbWriteReg,
    input  logic [DATA_W-1:0] MemWbResult,
    output logic [DATA_W-1:0] DataIn1,
    output logic [DATA_W-1:0] DataIn2,
    output logic [1:0]        AluCtrl,
    output logic [DATA_W-1:0] StoreData,
    output logic              OutValid,
    output logic [REG_AW-1:0] OutWriteReg,
    output logic [3:0]        OutCtrl,
    output logic              LoadUseStall
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              alu_src;
        logic [1:0]        alu_ctrl;
        logic [REG_AW-1:0] write_reg;
        logic [3:0]        ctrl;
    } stage_t;

    stage_t            r_stage;
    stage_t            w_next;
    logic              w_load_use;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    always_comb begin
        w_next           = '0;
        w_next.valid     = InValid;
        w_next.rs        = InRs;
        w_next.rt        = InRt;
        w_next.rs_data   = InRsData;
        w_next.rt_data   = InRtData;
        w_next.imm       = InImm;
        w_next.alu_src   = InAluSrc;
        w_next.alu_ctrl  = InAluCtrl;
        w_next.write_reg = InWriteReg;
        w_next.ctrl      = InCtrl;
    end

    // ctrl[2] is MemRead; register 0 never creates a dependency.
    always_comb begin
        w_load_use = 1'b0;
        if (!Flush && r_stage.valid && r_stage.ctrl[2] && (r_stage.write_reg != '0) && InValid &&
            ((r_stage.write_reg == InRs) || (r_stage.write_reg == InRt)))
            w_load_use = 1'b1;
    end

    // Bubbles (flush or load-use) clear the whole stage, data included.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_stage <= '0;
        else if (Flush)
            r_stage <= '0;
        else if (Stall)
            r_stage <= r_stage;
        else if (w_load_use)
            r_stage <= '0;
        else
            r_stage <= w_next;
    end

    // EX/MEM has the younger result, so it wins over MEM/WB.
    always_comb begin
        w_fwd_rs = r_stage.rs_data;
        if (ExMemRegWrite && (ExMemWriteReg != '0) && (ExMemWriteReg == r_stage.rs))
            w_fwd_rs = ExMemResult;
        else if (MemWbRegWrite && (MemWbWriteReg != '0) && (MemWbWriteReg == r_stage.rs))
            w_fwd_rs = MemWbResult;
    end

    always_comb begin
        w_fwd_rt = r_stage.rt_data;
        if (ExMemRegWrite && (ExMemWriteReg != '0) && (ExMemWriteReg == r_stage.rt))
            w_fwd_rt = ExMemResult;
        else if (MemWbRegWrite && (MemWbWriteReg != '0) && (MemWbWriteReg == r_stage.rt))
            w_fwd_rt = MemWbResult;
    end

    assign DataIn1      = w_fwd_rs;
    assign DataIn2      = r_stage.alu_src ? r_stage.imm : w_fwd_rt;
    assign StoreData    = w_fwd_rt;
    assign AluCtrl      = r_stage.alu_ctrl;
    assign OutValid     = r_stage.valid;
    assign OutWriteReg  = r_stage.write_reg;
    assign OutCtrl      = r_stage.valid ? r_stage.ctrl : 4'b0000;
    assign LoadUseStall = w_load_use;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: reset, forwarding priority, immediate select,
// load-use bubble, flush/stall interaction and asynchronous reset during a stall.
module tb_idex_operand_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              Clk = 1'b0;
    logic              Rst_n;
    logic              Stall, Flush, InValid;
    logic [REG_AW-1:0] InRs, InRt, InWriteReg;
    logic [DATA_W-1:0] InRsData, InRtData, InImm;
    logic              InAluSrc;
    logic [1:0]        InAluCtrl;
    logic [3:0]        InCtrl;
    logic              ExMemRegWrite, MemWbRegWrite;
    logic [REG_AW-1:0] ExMemWriteReg, MemWbWriteReg;
    logic [DATA_W-1:0] ExMemResult, MemWbResult;
    logic [DATA_W-1:0] DataIn1, DataIn2, StoreData;
    logic [1:0]        AluCtrl;
    logic              OutValid, LoadUseStall;
    logic [REG_AW-1:0] OutWriteReg;
    logic [3:0]        OutCtrl;

    int checks   = 0;
    int failures = 0;

    idex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .InRs(InRs), .InRt(InRt), .InRsData(InRsData), .InRtData(InRtData), .InImm(InImm),
        .InAluSrc(InAluSrc), .InAluCtrl(InAluCtrl), .InWriteReg(InWriteReg), .InCtrl(InCtrl),
        .ExMemRegWrite(ExMemRegWrite), .ExMemWriteReg(ExMemWriteReg), .ExMemResult(ExMemResult),
        .MemWbRegWrite(MemWbRegWrite), .MemWbWriteReg(MemWbWriteReg), .MemWbResult(MemWbResult),
        .DataIn1(DataIn1), .DataIn2(DataIn2), .AluCtrl(AluCtrl), .StoreData(StoreData),
        .OutValid(OutValid), .OutWriteReg(OutWriteReg), .OutCtrl(OutCtrl),
        .LoadUseStall(LoadUseStall)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic decode(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                          input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                          input logic [DATA_W-1:0] imm, input logic src, input logic [1:0] op,
                          input logic [REG_AW-1:0] wr, input logic [3:0] ctrl);
        InValid = 1'b1; InRs = rs; InRt = rt; InRsData = rsd; InRtData = rtd;
        InImm = imm; InAluSrc = src; InAluCtrl = op; InWriteReg = wr; InCtrl = ctrl;
    endtask

    initial begin
        // Reset with random inputs everywhere
        Rst_n = 1'b0;
        Stall = 1'($urandom); Flush = 1'($urandom); InValid = 1'($urandom);
        InRs = REG_AW'($urandom); InRt = REG_AW'($urandom); InWriteReg = REG_AW'($urandom);
        InRsData = $urandom; InRtData = $urandom; InImm = $urandom;
        InAluSrc = 1'($urandom); InAluCtrl = 2'($urandom); InCtrl = 4'($urandom);
        ExMemRegWrite = 1'($urandom); ExMemWriteReg = REG_AW'($urandom); ExMemResult = $urandom;
        MemWbRegWrite = 1'($urandom); MemWbWriteReg = REG_AW'($urandom); MemWbResult = $urandom;
        repeat (2) tick();
        chk("rst_DataIn1", DataIn1, 32'h0);
        chk("rst_DataIn2", DataIn2, 32'h0);
        chk("rst_StoreData", StoreData, 32'h0);
        chk("rst_AluCtrl", 32'(AluCtrl), 32'h0);
        chk("rst_OutValid", 32'(OutValid), 32'h0);
        chk("rst_OutWriteReg", 32'(OutWriteReg), 32'h0);
        chk("rst_OutCtrl", 32'(OutCtrl), 32'h0);
        chk("rst_LoadUseStall", 32'(LoadUseStall), 32'h0);

        // Release and load add r3 = r1 + r2
        #2;
        Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
        ExMemRegWrite = 1'b0; MemWbRegWrite = 1'b0;
        ExMemWriteReg = '0; MemWbWriteReg = '0;
        decode(5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, 2'b00, 5'd3, 4'b1000);
        tick();
        chk("add_DataIn1", DataIn1, 32'd10);
        chk("add_DataIn2", DataIn2, 32'd20);
        chk("add_AluCtrl", 32'(AluCtrl), 32'h0);
        chk("add_OutValid", 32'(OutValid), 32'h1);
        chk("add_OutWriteReg", 32'(OutWriteReg), 32'd3);
        chk("add_OutCtrl", 32'(OutCtrl), 32'h8);

        // Forwarding priority on rs=3
        decode(5'd3, 5'd4, 32'h11, 32'h22, 32'd0, 1'b0, 2'b01, 5'd7, 4'b1000);
        tick();
        ExMemRegWrite = 1'b1; ExMemWriteReg = 5'd3; ExMemResult = 32'h55;
        MemWbRegWrite = 1'b1; MemWbWriteReg = 5'd3; MemWbResult = 32'h66;
        #1 chk("fwd_exmem_wins", DataIn1, 32'h55);
        chk("fwd_rt_untouched", DataIn2, 32'h22);
        ExMemRegWrite = 1'b0;
        #1 chk("fwd_memwb", DataIn1, 32'h66);
        ExMemRegWrite = 1'b1; ExMemWriteReg = 5'd0; MemWbWriteReg = 5'd0;
        #1 chk("fwd_r0_raw", DataIn1, 32'h11);

        // Immediate select with forwarded rt
        ExMemRegWrite = 1'b0; MemWbRegWrite = 1'b0;
        decode(5'd1, 5'd4, 32'h1, 32'h99, 32'hFFFF_FFFC, 1'b1, 2'b10, 5'd8, 4'b1000);
        tick();
        MemWbRegWrite = 1'b1; MemWbWriteReg = 5'd4; MemWbResult = 32'd7;
        #1 chk("imm_DataIn2", DataIn2, 32'hFFFF_FFFC);
        chk("imm_StoreData", StoreData, 32'd7);
        chk("imm_AluCtrl", 32'(AluCtrl), 32'h2);

        // Load-use: lw r5 in stage, decode add r6,r5,r1
        MemWbRegWrite = 1'b0;
        decode(5'd2, 5'd0, 32'h40, 32'h0, 32'h4, 1'b1, 2'b00, 5'd5, 4'b1101);
        tick();
        chk("lw_OutCtrl", 32'(OutCtrl), 32'hD);
        decode(5'd5, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 5'd6, 4'b1000);
        #1 chk("lu_stall", 32'(LoadUseStall), 32'h1);
        Flush = 1'b1;
        #1 chk("lu_masked_by_flush", 32'(LoadUseStall), 32'h0);
        Flush = 1'b0;
        tick();
        chk("lu_bubble_valid", 32'(OutValid), 32'h0);
        chk("lu_bubble_ctrl", 32'(OutCtrl), 32'h0);
        chk("lu_bubble_data", DataIn1, 32'h0);
        decode(5'd2, 5'd0, 32'h40, 32'h0, 32'h4, 1'b1, 2'b00, 5'd0, 4'b1101);
        tick();
        chk("lw_r0_valid", 32'(OutValid), 32'h1);
        decode(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 5'd6, 4'b1000);
        #1 chk("lu_r0_nostall", 32'(LoadUseStall), 32'h0);

        // Reserved op passes through; then Flush+Stall loads a bubble
        decode(5'd7, 5'd8, 32'h1234, 32'h5678, 32'h0, 1'b0, 2'b11, 5'd9, 4'b1000);
        tick();
        chk("rsv_AluCtrl", 32'(AluCtrl), 32'h3);
        chk("rsv_DataIn1", DataIn1, 32'h1234);
        Flush = 1'b1; Stall = 1'b1;
        tick();
        chk("fs_OutValid", 32'(OutValid), 32'h0);
        chk("fs_OutCtrl", 32'(OutCtrl), 32'h0);
        chk("fs_DataIn1", DataIn1, 32'h0);
        Flush = 1'b0; Stall = 1'b0;
        tick();
        Stall = 1'b1;
        decode(5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'h0, 1'b1, 2'b01, 5'd12, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_DataIn1", DataIn1, 32'h1234);
            chk("stall_DataIn2", DataIn2, 32'h5678);
            chk("stall_AluCtrl", 32'(AluCtrl), 32'h3);
            chk("stall_OutWriteReg", 32'(OutWriteReg), 32'd9);
            chk("stall_OutCtrl", 32'(OutCtrl), 32'h8);
        end

        // Asynchronous reset between edges while stalled
        #3 Rst_n = 1'b0;
        #1;
        chk("arst_DataIn1", DataIn1, 32'h0);
        chk("arst_DataIn2", DataIn2, 32'h0);
        chk("arst_OutValid", 32'(OutValid), 32'h0);
        chk("arst_AluCtrl", 32'(AluCtrl), 32'h0);
        chk("arst_OutWriteReg", 32'(OutWriteReg), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
